// File: rtl/bus_response_if.sv
// ---------------------------------------------------------------------------
// bus_response_if
// Bundles the master-facing bus signals of bus_response: the master request
// (cyc/stb/adr), the decoder results (sel/invalid), the per-slave
// acknowledge and read-data vectors, and the response back to the master.
//
// Modports:
//   slave  - used by bus_response (it answers the master's request)
//   master - used by whatever drives the request side (bench or interconnect)
//
// Handshake: a request is cyc_i & stb_i sampled on a rising clock edge while
// the responder is idle. The responder answers with exactly one single-cycle
// pulse of ack_o (dat_o valid in that cycle) or err_o; cyc_i must stay high
// until that pulse, and dropping cyc_i earlier abandons the transfer silently.
// ---------------------------------------------------------------------------
interface bus_response_if #(
    parameter int NSLV = 9
) ();
    logic                 cyc_i;
    logic                 stb_i;
    logic [31:0]          adr_i;
    logic [NSLV-1:0]      sel_i;
    logic                 invalid_i;
    logic [NSLV-1:0]      ack_s_i;
    logic [32*NSLV-1:0]   dat_s_i;
    logic                 ack_o;
    logic                 err_o;
    logic [31:0]          dat_o;

    modport slave (
        input  cyc_i, stb_i, adr_i, sel_i, invalid_i, ack_s_i, dat_s_i,
        output ack_o, err_o, dat_o
    );

    modport master (
        output cyc_i, stb_i, adr_i, sel_i, invalid_i, ack_s_i, dat_s_i,
        input  ack_o, err_o, dat_o
    );
endinterface

// File: rtl/bus_response.sv
// ---------------------------------------------------------------------------
// bus_response
// Response path of a shared bus: waits for the decoded slave to acknowledge,
// returns its read data, or raises a bus error on an undecodable address,
// a bad select vector, or an acknowledge timeout. Errors are counted
// (saturating) and the faulting address is captured.
//
// Ports:
//   clk_i        - clock, rising edge
//   rst_n        - asynchronous active-low reset
//   bus          - bus_response_if.slave (request, decoder, slave acks/data,
//                  ack_o/err_o/dat_o back to the master)
//   busy_o       - high whenever the FSM is not IDLE
//   err_cnt_o    - saturating bus-error count
//   err_adr_o    - address of the most recent bus error
//   dbg_state_o  - current FSM state (0 IDLE, 1 WAIT, 2 RESP)
// ---------------------------------------------------------------------------
module bus_response #(
    parameter int TIMEOUT = 255,
    parameter int NSLV    = 9
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    bus_response_if.slave        bus,
    output logic                 busy_o,
    output logic [7:0]           err_cnt_o,
    output logic [31:0]          err_adr_o,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [7:0]      TMO = TIMEOUT[7:0];
    localparam logic [NSLV-1:0] ONE = 1;

    state_t          state_q, state_d;
    logic [NSLV-1:0] sel_q, sel_d;
    logic [31:0]     adr_q, adr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            resp_err_q, resp_err_d;   // pending response is an error
    logic [31:0]     dat_q, dat_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [31:0]     err_adr_q, err_adr_d;

    logic            req;
    logic            sel_onehot;
    logic            bad_req;
    logic            sel_ack;
    logic [31:0]     sel_data;

    assign req        = bus.cyc_i & bus.stb_i;
    // x & (x-1) clears the lowest set bit; zero result means at most one bit.
    assign sel_onehot = (bus.sel_i != '0) && ((bus.sel_i & (bus.sel_i - ONE)) == '0);
    assign bad_req    = bus.invalid_i | ~sel_onehot;
    // Masking with sel_q makes acks from unselected slaves invisible.
    assign sel_ack    = |(bus.ack_s_i & sel_q);

    // sel_q is one-hot whenever WAIT is entered, so OR-ing masked slots
    // yields exactly the selected slave's word.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (sel_q[k]) begin
                sel_data = sel_data | bus.dat_s_i[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        adr_d      = adr_q;
        cnt_d      = cnt_q;
        resp_err_d = resp_err_q;
        dat_d      = dat_q;
        err_cnt_d  = err_cnt_q;
        err_adr_d  = err_adr_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    sel_d = bus.sel_i;
                    adr_d = bus.adr_i;
                    cnt_d = '0;
                    if (bad_req) begin
                        resp_err_d = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.cyc_i) begin
                    // Master abandoned the cycle: leave without responding.
                    state_d = S_IDLE;
                end else if (sel_ack) begin
                    // Checked before the timeout so a last-cycle ack wins.
                    dat_d      = sel_data;
                    resp_err_d = 1'b0;
                    state_d    = S_RESP;
                end else if (cnt_q == TMO) begin
                    resp_err_d = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (resp_err_q) begin
                    err_adr_d = adr_q;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            adr_q      <= '0;
            cnt_q      <= '0;
            resp_err_q <= 1'b0;
            dat_q      <= '0;
            err_cnt_q  <= '0;
            err_adr_q  <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            adr_q      <= adr_d;
            cnt_q      <= cnt_d;
            resp_err_q <= resp_err_d;
            dat_q      <= dat_d;
            err_cnt_q  <= err_cnt_d;
            err_adr_q  <= err_adr_d;
        end
    end

    // Responses decode straight from the state register, so reset clears
    // them immediately and RESP lasts exactly one cycle.
    assign bus.ack_o   = (state_q == S_RESP) && !resp_err_q;
    assign bus.err_o   = (state_q == S_RESP) &&  resp_err_q;
    assign bus.dat_o   = dat_q;
    assign busy_o      = (state_q != S_IDLE);
    assign err_cnt_o   = err_cnt_q;
    assign err_adr_o   = err_adr_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/bus_response.md
BUS_RESPONSE -- requirements
Module: bus_response

Interface
REQ-001 Parameter TIMEOUT, default 255: max wait cycles for a slave acknowledge before bus error; legal range 1..255.
REQ-002 Parameter NSLV, default 9: slave count; bit order is flash, dram, sram, led_matrix, monitor, kbd, encoder, serial0, serial1 (bit 0..8).
REQ-003 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-005 cyc_i  in  1  master bus cycle active.
REQ-006 stb_i  in  1  master strobe; a request is cyc_i & stb_i.
REQ-007 adr_i  in  32  master address, for error capture only.
REQ-008 sel_i  in  NSLV  one-hot slave selects from the address decoder.
REQ-009 invalid_i  in  1  decoder flag: address maps to no slave.
REQ-010 ack_s_i  in  NSLV  per-slave acknowledge.
REQ-011 dat_s_i  in  32*NSLV  per-slave read data; slave k occupies bits 32k+31:32k.
REQ-012 ack_o  out  1  one-cycle acknowledge to master.
REQ-013 err_o  out  1  one-cycle bus error to master.
REQ-014 dat_o  out  32  registered read data, valid with ack_o.
REQ-015 busy_o  out  1  high in any state other than IDLE.
REQ-016 err_cnt_o  out  8  saturating count of bus errors.
REQ-017 err_adr_o  out  32  address of most recent bus error.

Function
REQ-018 FSM states IDLE, WAIT, RESP; encoding free.
REQ-019 IDLE: on cyc_i & stb_i, latch sel_i into sel_q and adr_i into adr_q, clear wait counter, go WAIT.
REQ-020 IDLE request with invalid_i=1, sel_i=0, or more than one sel_i bit set: go RESP with error pending; no slave is waited on.
REQ-021 WAIT: each cycle, if (ack_s_i & sel_q) != 0, register selected slave's dat_s_i into dat_o, go RESP with ack pending.
REQ-022 WAIT: otherwise increment 8-bit counter; when counter equals TIMEOUT with no ack, go RESP with error pending.
REQ-023 Ack and timeout in the same cycle: ack wins.
REQ-024 Acks on unselected ack_s_i bits are ignored in every state.
REQ-025 RESP: assert exactly one of ack_o or err_o for exactly one cycle, then return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-026 Minimum latency: request cycle N, slave ack in cycle N+1 -> ack_o high in cycle N+2.
REQ-027 Invalid-address latency: request cycle N -> err_o high in cycle N+1.
REQ-028 cyc_i low in WAIT: abort to IDLE next cycle; no ack_o, no err_o, err_cnt_o unchanged.
REQ-029 On every err_o pulse: err_adr_o <= adr_q; err_cnt_o increments, saturating at 255.
REQ-030 dat_o holds its value except when loaded per REQ-021; dat_o is not loaded on error.
REQ-031 ack_o and err_o are never high in the same cycle.

Reset
REQ-032 rst_n low: state IDLE, ack_o=0, err_o=0, dat_o=0, busy_o=0, err_cnt_o=0, err_adr_o=0, counter=0, sel_q=0, adr_q=0, immediately and independent of clk_i.
REQ-033 Reset mid-WAIT or mid-RESP: pending ack/err is discarded; after release the block sits in IDLE.
REQ-034 First request is accepted on the first rising edge after rst_n deasserts.

Verification
REQ-035 sram read: sel_i=0x004, adr_i=0x00000100, ack_s_i[2] one cycle later with data 0xDEADBEEF -> ack_o one cycle, dat_o=0xDEADBEEF, latency 2 cycles.
REQ-036 Invalid: adr_i=0x01000000, invalid_i=1 -> err_o high next cycle, err_adr_o=0x01000000, err_cnt_o=1, ack_o stays 0.
REQ-037 Timeout: sel_i=0x001 (flash), no ack, TIMEOUT=4 -> err_o once, 6 cycles after request; busy_o high throughout.
REQ-038 Wrong-slave ack: sel_i=0x100, ack_s_i[0] pulsed, then ack_s_i[8] with 0x12345678 -> only second produces ack_o, dat_o=0x12345678.
REQ-039 Abort and reset: drop cyc_i in WAIT -> IDLE, no response; separately assert rst_n low in WAIT -> all outputs 0 at once, no response after release.
REQ-040 Saturation: 300 invalid requests -> err_cnt_o=255, err_adr_o equals last invalid address.
